// File: rtl/key_conditioner.sv
// Front-panel input conditioner for the microwave: synchronizes raw contacts,
// debounces the keypad into a clean one-hot code with a press strobe, and debounces the buttons.

module key_conditioner #(
   parameter int DB_CYCLES = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [9:0] key_raw,
   input  logic       startn_raw,
   input  logic       stopn_raw,
   input  logic       clearn_raw,
   input  logic       door_raw,
   output logic [9:0] keypad,
   output logic       key_strobe,
   output logic       startn,
   output logic       stopn,
   output logic       clearn,
   output logic       door_closed
);

   // Button bit order everywhere below: {door, clearn, stopn, startn}
   localparam logic [3:0]       BtnRst  = 4'b0111;
   localparam logic [13:0]      SyncRst = {BtnRst, 10'b0};
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HELD,
      RELEASE
   } key_state_e;

   logic [13:0] meta_q;
   logic [13:0] sync_q;
   logic [9:0]  keySync;
   logic [3:0]  btnSync;

   key_state_e       state_q, state_d;
   logic [9:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [9:0]       keypad_q, keypad_d;
   logic             strobe_q, strobe_d;

   logic [3:0]            btnLevel_q, btnLevel_d;
   logic [3:0][CNT_W-1:0] btnCnt_q, btnCnt_d;

   // Synchronizers reset to the inactive level so nothing looks pressed after reset
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta_q <= SyncRst;
         sync_q <= SyncRst;
      end else begin
         meta_q <= {door_raw, clearn_raw, stopn_raw, startn_raw, key_raw};
         sync_q <= meta_q;
      end
   end

   assign keySync = sync_q[9:0];
   assign btnSync = sync_q[13:10];

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      keypad_d = keypad_q;
      strobe_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            keypad_d = '0;
            cnt_d    = '0;
            if ($onehot(keySync)) begin
               cand_d  = keySync;
               cnt_d   = CntOne;
               state_d = ARM;
            end
         end
         ARM: begin
            if (keySync != cand_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CntLast) begin
               cnt_d    = '0;
               keypad_d = cand_q;
               strobe_d = 1'b1;
               state_d  = HELD;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         HELD: begin
            cnt_d = '0;
            if (keySync != cand_q) begin
               cnt_d   = CntOne;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Only an unbroken run of all-zero samples completes a release
            if (keySync == '0) begin
               if (cnt_q == CntLast) begin
                  cnt_d    = '0;
                  keypad_d = '0;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end else if (keySync == cand_q) begin
               cnt_d   = '0;
               state_d = HELD;
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            cnt_d    = '0;
            keypad_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         keypad_q <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         keypad_q <= keypad_d;
         strobe_q <= strobe_d;
      end
   end

   // Each button counts consecutive samples that disagree with its current output
   always_comb begin
      btnLevel_d = btnLevel_q;
      btnCnt_d   = '0;
      for (int i = 0; i < 4; i++) begin
         if (btnSync[i] != btnLevel_q[i]) begin
            if (btnCnt_q[i] == CntLast) begin
               btnLevel_d[i] = btnSync[i];
            end else begin
               btnCnt_d[i] = btnCnt_q[i] + CntOne;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         btnLevel_q <= BtnRst;
         btnCnt_q   <= '0;
      end else begin
         btnLevel_q <= btnLevel_d;
         btnCnt_q   <= btnCnt_d;
      end
   end

   assign keypad      = keypad_q;
   assign key_strobe  = strobe_q;
   assign startn      = btnLevel_q[0];
   assign stopn       = btnLevel_q[1];
   assign clearn      = btnLevel_q[2];
   assign door_closed = btnLevel_q[3];

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed latency/boundary scenarios plus
// randomized keypad and button traffic checked against a run-length reference model.

module tb_key_conditioner;

   localparam int         DB       = 8;
   localparam logic [3:0] BTN_IDLE = 4'b0111;
   localparam logic [13:0] RAW_IDLE = {BTN_IDLE, 10'b0};

   logic       clock;
   logic       resetn;
   logic [9:0] keyRaw;
   logic       startnRaw, stopnRaw, clearnRaw, doorRaw;
   logic [9:0] keypad;
   logic       keyStrobe;
   logic       startn, stopn, clearn, doorClosed;
   logic [3:0] dutBtn;

   int compared;
   int mismatched;
   int dutStrobes;

   // Reference model: sync stream is the raw stream delayed two edges; outputs follow run lengths
   logic [13:0] rawQ[$];
   logic [9:0]  mKeypad;
   logic        mStrobe;
   logic [3:0]  mBtn;
   logic [9:0]  keyRunVal;
   int          keyRunLen;
   logic [3:0]  btnRunVal;
   int          btnRunLen[4];

   key_conditioner #(.DB_CYCLES(DB), .CNT_W(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .key_raw    (keyRaw),
      .startn_raw (startnRaw),
      .stopn_raw  (stopnRaw),
      .clearn_raw (clearnRaw),
      .door_raw   (doorRaw),
      .keypad     (keypad),
      .key_strobe (keyStrobe),
      .startn     (startn),
      .stopn      (stopn),
      .clearn     (clearn),
      .door_closed(doorClosed)
   );

   assign dutBtn = {doorClosed, clearn, stopn, startn};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic modelReset();
      rawQ      = '{RAW_IDLE, RAW_IDLE};
      mKeypad   = '0;
      mStrobe   = 1'b0;
      mBtn      = BTN_IDLE;
      keyRunVal = '0;
      keyRunLen = 0;
      btnRunVal = BTN_IDLE;
      for (int i = 0; i < 4; i++) btnRunLen[i] = 0;
   endtask

   task automatic modelStep(input logic [13:0] raw);
      logic [13:0] s;
      rawQ.push_back(raw);
      s = rawQ.pop_front();
      if (s[9:0] == keyRunVal) begin
         if (keyRunLen < 1000) keyRunLen++;
      end else begin
         keyRunVal = s[9:0];
         keyRunLen = 1;
      end
      mStrobe = 1'b0;
      if (mKeypad == '0) begin
         if ($countones(keyRunVal) == 1 && keyRunLen == DB) begin
            mKeypad = keyRunVal;
            mStrobe = 1'b1;
         end
      end else if (keyRunVal == '0 && keyRunLen == DB) begin
         mKeypad = '0;
      end
      for (int i = 0; i < 4; i++) begin
         if (s[10+i] == btnRunVal[i]) begin
            if (btnRunLen[i] < 1000) btnRunLen[i]++;
         end else begin
            btnRunVal[i] = s[10+i];
            btnRunLen[i] = 1;
         end
         if (btnRunVal[i] != mBtn[i] && btnRunLen[i] == DB) mBtn[i] = btnRunVal[i];
      end
   endtask

   task automatic applyStimulus(input logic [9:0] k, input logic [3:0] b);
      keyRaw = k;
      {doorRaw, clearnRaw, stopnRaw, startnRaw} = b;
      @(posedge clock);
      modelStep({b, k});
      #1;
      if (keyStrobe === 1'b1) dutStrobes++;
   endtask

   task automatic doReset();
      resetn = 1'b0;
      keyRaw = '0;
      {doorRaw, clearnRaw, stopnRaw, startnRaw} = BTN_IDLE;
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      modelReset();
      dutStrobes = 0;
   endtask

   task automatic test_reset();
      keyRaw = '0;
      {doorRaw, clearnRaw, stopnRaw, startnRaw} = BTN_IDLE;
      repeat (2) @(posedge clock);
      #1;
      compared++;
      if (keypad !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL reset_keypad: got %h expected 000", keypad);
      end
      compared++;
      if (keyStrobe !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_strobe: got %b expected 0", keyStrobe);
      end
      compared++;
      if (dutBtn !== BTN_IDLE) begin
         mismatched++;
         $display("[TB] FAIL reset_buttons: got %b expected %b", dutBtn, BTN_IDLE);
      end
      resetn = 1'b1;
      modelReset();
      dutStrobes = 0;
   endtask

   task automatic test_clean_press();
      int first, rel, early;
      doReset();
      first = -1;
      early = 0;
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(10'h008, BTN_IDLE);
         if (keyStrobe === 1'b1 && first < 0) first = n;
         if (n < 10 && keypad !== 10'h000) early++;
      end
      compared++;
      if (first !== 10 || early !== 0) begin
         mismatched++;
         $display("[TB] FAIL press_latency: strobe edge %0d early %0d expected edge 10 early 0", first, early);
      end
      compared++;
      if (dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL press_strobe_count: got %0d expected 1", dutStrobes);
      end
      compared++;
      if (keypad !== 10'h008) begin
         mismatched++;
         $display("[TB] FAIL press_hold_keypad: got %h expected 008", keypad);
      end
      rel = -1;
      for (int n = 1; n <= 12; n++) begin
         applyStimulus(10'h000, BTN_IDLE);
         if (keypad === 10'h000 && rel < 0) rel = n;
      end
      compared++;
      if (rel !== 10 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL release_latency: edge %0d strobes %0d expected edge 10 strobes 1", rel, dutStrobes);
      end
   endtask

   task automatic test_bounce_press();
      int noisy, first;
      doReset();
      noisy = 0;
      for (int seg = 0; seg < 10; seg++) begin
         repeat (3) begin
            applyStimulus((seg % 2 == 0) ? 10'h020 : 10'h000, BTN_IDLE);
            if (keypad !== 10'h000 || keyStrobe !== 1'b0) noisy++;
         end
      end
      compared++;
      if (noisy !== 0) begin
         mismatched++;
         $display("[TB] FAIL bounce_quiet: got %0d active cycles expected 0", noisy);
      end
      first = -1;
      for (int n = 1; n <= 14; n++) begin
         applyStimulus(10'h020, BTN_IDLE);
         if (keypad === 10'h020 && first < 0) first = n;
      end
      compared++;
      if (first !== 10 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL bounce_accept: edge %0d strobes %0d expected edge 10 strobes 1", first, dutStrobes);
      end
   endtask

   task automatic test_two_keys();
      int changed, rel;
      doReset();
      repeat (12) applyStimulus(10'h004, BTN_IDLE);
      compared++;
      if (keypad !== 10'h004 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL two_keys_first: keypad %h strobes %0d expected 004 strobes 1", keypad, dutStrobes);
      end
      changed = 0;
      repeat (15) begin
         applyStimulus(10'h084, BTN_IDLE);
         if (keypad !== 10'h004) changed++;
      end
      compared++;
      if (changed !== 0 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL two_keys_hold: changed %0d strobes %0d expected 0 and 1", changed, dutStrobes);
      end
      rel = -1;
      for (int n = 1; n <= 14; n++) begin
         applyStimulus(10'h000, BTN_IDLE);
         if (keypad === 10'h000 && rel < 0) rel = n;
      end
      compared++;
      if (rel !== 10 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL two_keys_release: edge %0d strobes %0d expected edge 10 strobes 1", rel, dutStrobes);
      end
   endtask

   task automatic test_boundary();
      int first;
      doReset();
      repeat (DB - 1) applyStimulus(10'h001, BTN_IDLE);
      repeat (12) applyStimulus(10'h000, BTN_IDLE);
      compared++;
      if (dutStrobes !== 0 || keypad !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL short_press: strobes %0d keypad %h expected 0 and 000", dutStrobes, keypad);
      end
      first = -1;
      for (int n = 1; n <= 12; n++) begin
         applyStimulus((n <= DB) ? 10'h002 : 10'h000, BTN_IDLE);
         if (keypad === 10'h002 && first < 0) first = n;
      end
      compared++;
      if (first !== 10 || dutStrobes !== 1) begin
         mismatched++;
         $display("[TB] FAIL exact_press: edge %0d strobes %0d expected edge 10 strobes 1", first, dutStrobes);
      end
   endtask

   task automatic test_door();
      int early, rise;
      doReset();
      early = 0;
      for (int n = 1; n <= 15; n++) begin
         applyStimulus(10'h000, {(n <= 5) ? 1'b1 : 1'b0, 3'b111});
         if (doorClosed !== 1'b0) early++;
      end
      compared++;
      if (early !== 0) begin
         mismatched++;
         $display("[TB] FAIL door_glitch: got %0d closed cycles expected 0", early);
      end
      rise = -1;
      for (int n = 1; n <= 14; n++) begin
         applyStimulus(10'h000, 4'b1111);
         if (doorClosed === 1'b1 && rise < 0) rise = n;
      end
      compared++;
      if (rise !== 10) begin
         mismatched++;
         $display("[TB] FAIL door_close_latency: got edge %0d expected 10", rise);
      end
   endtask

   task automatic test_buttons();
      int startFall, clearFall, stopMoved;
      logic [3:0] b;
      doReset();
      startFall = -1;
      clearFall = -1;
      stopMoved = 0;
      for (int n = 1; n <= 14; n++) begin
         b = 4'b0110;
         if (n <= DB - 1) b[1] = 1'b0;
         if (n <= DB) b[2] = 1'b0;
         applyStimulus(10'h000, b);
         if (startn === 1'b0 && startFall < 0) startFall = n;
         if (clearn === 1'b0 && clearFall < 0) clearFall = n;
         if (stopn !== 1'b1) stopMoved++;
      end
      compared++;
      if (startFall !== 10) begin
         mismatched++;
         $display("[TB] FAIL startn_latency: got edge %0d expected 10", startFall);
      end
      compared++;
      if (clearFall !== 10) begin
         mismatched++;
         $display("[TB] FAIL clearn_exact_pulse: got edge %0d expected 10", clearFall);
      end
      compared++;
      if (stopMoved !== 0) begin
         mismatched++;
         $display("[TB] FAIL stopn_short_pulse: got %0d low cycles expected 0", stopMoved);
      end
   endtask

   task automatic test_reset_mid();
      int first, badStrobe;
      doReset();
      repeat (12) applyStimulus(10'h000, 4'b1111);
      compared++;
      if (doorClosed !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mid_door_setup: got %b expected 1", doorClosed);
      end
      repeat (5) applyStimulus(10'h010, 4'b1111);
      #2 resetn = 1'b0;
      #1;
      compared++;
      if (keypad !== 10'h000 || keyStrobe !== 1'b0 || dutBtn !== BTN_IDLE) begin
         mismatched++;
         $display("[TB] FAIL reset_in_arm: keypad %h strobe %b buttons %b expected 000 0 %b", keypad, keyStrobe, dutBtn, BTN_IDLE);
      end
      badStrobe = 0;
      repeat (3) begin
         @(posedge clock);
         #1;
         if (keyStrobe !== 1'b0 || keypad !== 10'h000) badStrobe++;
      end
      resetn = 1'b1;
      modelReset();
      dutStrobes = 0;
      first = -1;
      for (int n = 1; n <= 12; n++) begin
         applyStimulus(10'h010, 4'b1111);
         if (keyStrobe === 1'b1 && first < 0) first = n;
      end
      compared++;
      if (first !== 10 || badStrobe !== 0 || keypad !== 10'h010) begin
         mismatched++;
         $display("[TB] FAIL press_after_reset: edge %0d bad %0d keypad %h expected 10 0 010", first, badStrobe, keypad);
      end
      #2 resetn = 1'b0;
      #1;
      compared++;
      if (keypad !== 10'h000 || keyStrobe !== 1'b0 || dutBtn !== BTN_IDLE) begin
         mismatched++;
         $display("[TB] FAIL reset_in_held: keypad %h strobe %b buttons %b expected 000 0 %b", keypad, keyStrobe, dutBtn, BTN_IDLE);
      end
      doReset();
   endtask

   task automatic test_random();
      int segLeft, r, r2;
      bit zeroNext;
      logic [9:0] segVal;
      logic [3:0] b;
      doReset();
      segLeft = 0;
      zeroNext = 1'b1;
      segVal = '0;
      b = BTN_IDLE;
      for (int c = 0; c < 900; c++) begin
         if (segLeft == 0) begin
            if (zeroNext) begin
               segVal = '0;
            end else begin
               r = int'($urandom_range(0, 9));
               if ($urandom_range(0, 5) == 0) begin
                  r2 = (r + int'($urandom_range(1, 9))) % 10;
                  segVal = (10'b1 << r) | (10'b1 << r2);
               end else begin
                  segVal = 10'b1 << r;
               end
            end
            zeroNext = ~zeroNext;
            segLeft = int'($urandom_range(1, 14));
         end
         segLeft--;
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
         end
         applyStimulus(segVal, b);
         compared++;
         if (keypad !== mKeypad) begin
            mismatched++;
            $display("[TB] FAIL random_keypad cycle %0d: got %h expected %h", c, keypad, mKeypad);
         end
         compared++;
         if (keyStrobe !== mStrobe) begin
            mismatched++;
            $display("[TB] FAIL random_strobe cycle %0d: got %b expected %b", c, keyStrobe, mStrobe);
         end
         compared++;
         if (dutBtn !== mBtn) begin
            mismatched++;
            $display("[TB] FAIL random_buttons cycle %0d: got %b expected %b", c, dutBtn, mBtn);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      dutStrobes = 0;
      resetn     = 1'b0;
      keyRaw     = '0;
      {doorRaw, clearnRaw, stopnRaw, startnRaw} = BTN_IDLE;
      modelReset();
      test_reset();
      test_clean_press();
      test_bounce_press();
      test_two_keys();
      test_boundary();
      test_door();
      test_buttons();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
